// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus between the requesters, the arbiter and the async FIFO write port.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  logic [NUM_REQ-1:0]       i_Req_Valid;
  logic [NUM_REQ*WIDTH-1:0] i_Req_Data;
  logic [NUM_REQ-1:0]       i_Req_Last;
  logic [NUM_REQ-1:0]       o_Req_Ready;
  logic                     i_Full;
  logic                     o_WR_En;
  logic [WIDTH-1:0]         o_WR_Data;
  logic [NUM_REQ-1:0]       o_Grant;
  logic                     o_Busy;

  modport master (
    output i_Req_Valid, i_Req_Data, i_Req_Last, i_Full,
    input  o_Req_Ready, o_WR_En, o_WR_Data, o_Grant, o_Busy
  );

  modport slave (
    input  i_Req_Valid, i_Req_Data, i_Req_Last, i_Full,
    output o_Req_Ready, o_WR_En, o_WR_Data, o_Grant, o_Busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port among NUM_REQ requesters.
// A grant is held until a last-marked word or MAX_BURST words have been written.
module fifo_wr_arbiter_lane #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic             valid,
  input  logic             last,
  input  logic             full,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             wen,
  output logic             last_acc,
  output logic [WIDTH-1:0] data_q
);
  assign ready    = sel & ~full;
  assign wen      = ready & valid;
  assign last_acc = wen & last;
  assign data_q   = wen ? data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             i_WR_clk,
  input  logic             i_WR_rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                          state, state_n;
  logic [IW-1:0]                   rr_ptr, rr_n, owner, owner_n, pick, idx;
  logic [IW:0]                     scan;
  logic                            found;
  logic [CW-1:0]                   cnt, cnt_n, cnt_inc;
  logic [NUM_REQ-1:0]              grant, grant_n, sel, rdy, wen, last_acc;
  logic [NUM_REQ-1:0][WIDTH-1:0]   data_m;
  logic                            wr_en, last_hit, rel;
  logic [WIDTH-1:0]                wr_data;

  // Reset gates the lane selects so nothing is written while reset is held.
  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_REQ; k++)
      sel[k] = (state == GRANT) && !i_WR_rst && (owner == IW'(k));
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    fifo_wr_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
      .sel      (sel[k]),
      .valid    (bus.i_Req_Valid[k]),
      .last     (bus.i_Req_Last[k]),
      .full     (bus.i_Full),
      .data     (bus.i_Req_Data[k*WIDTH +: WIDTH]),
      .ready    (rdy[k]),
      .wen      (wen[k]),
      .last_acc (last_acc[k]),
      .data_q   (data_m[k])
    );
  end

  always_comb begin
    wr_data = '0;
    for (int k = 0; k < NUM_REQ; k++) wr_data = wr_data | data_m[k];
  end

  assign wr_en    = |wen;
  assign last_hit = |last_acc;
  assign cnt_inc  = cnt + 1'b1;
  assign rel      = wr_en && (last_hit || (cnt_inc == CW'(MAX_BURST)));

  // First valid requester at or above the rr pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, rr_ptr} + (IW+1)'(i);
      if (scan >= (IW+1)'(NUM_REQ)) scan = scan - (IW+1)'(NUM_REQ);
      idx = scan[IW-1:0];
      if (!found && bus.i_Req_Valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    owner_n = owner;
    cnt_n   = cnt;
    grant_n = grant;
    case (state)
      IDLE: if (found) begin
        state_n = GRANT;
        owner_n = pick;
        cnt_n   = '0;
        grant_n = NUM_REQ'(1) << pick;
      end
      GRANT: if (rel) begin
        state_n = IDLE;
        grant_n = '0;
        cnt_n   = '0;
        rr_n    = (owner == IW'(NUM_REQ-1)) ? '0 : owner + 1'b1;
      end else if (wr_en) begin
        cnt_n   = cnt_inc;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_WR_clk) begin
    if (i_WR_rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      cnt    <= '0;
      grant  <= '0;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_n;
      owner  <= owner_n;
      cnt    <= cnt_n;
      grant  <= grant_n;
    end
  end

  assign bus.o_Req_Ready = rdy;
  assign bus.o_WR_En     = wr_en;
  assign bus.o_WR_Data   = wr_data;
  assign bus.o_Grant     = grant;
  assign bus.o_Busy      = (state == GRANT);
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the asynchronous FIFO among NUM_REQ requesters in the write clock domain. It grants one requester at a time for a burst, and the burst ends on a last-word marker or after MAX_BURST words. The write enable and data go straight to the FIFO write side, and writes are back-pressured by the FIFO full flag. It sits between the producer logic and the FIFO write-pointer/full logic.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 8, data word width
MAX_BURST, 4, max words per grant (>=1); counter width $clog2(MAX_BURST+1)

Ports:
i_WR_clk  in  1  write-domain clock; all logic on posedge
i_WR_rst  in  1  reset: synchronous, active-high
i_Req_Valid  in  NUM_REQ  per-requester word valid
i_Req_Data  in  NUM_REQ*WIDTH  packed data; requester k occupies [k*WIDTH +: WIDTH]
i_Req_Last  in  NUM_REQ  marks last word of requester's packet
o_Req_Ready  out  NUM_REQ  per-requester accept; at most one bit high
i_Full  in  1  FIFO full flag (registered, write domain)
o_WR_En  out  1  FIFO write enable
o_WR_Data  out  WIDTH  FIFO write data
o_Grant  out  NUM_REQ  registered one-hot owner; all-zero when idle
o_Busy  out  1  high in GRANT state

Behaviour:
- Reset (sync, i_WR_rst=1 at posedge): state=IDLE, rr pointer=0, owner=0, burst count=0, o_Grant=0, o_Busy=0. o_Req_Ready=0, o_WR_En=0 and o_WR_Data=0 combinationally during and after reset.
- Reset has priority over all other events. Reset mid-burst drops the grant at that edge. Partially sent packets are not resumed.
- States: IDLE, GRANT.
- IDLE: if any i_Req_Valid bit is set, select the first valid index scanning upward from the rr pointer, wrapping modulo NUM_REQ. Next edge: owner=index, o_Grant=onehot(index), count=0, state=GRANT. With no valid bits, stay in IDLE.
- Arbitration latency is 1 cycle. No data moves in IDLE.
- GRANT, combinational:
  - o_Req_Ready[owner] = ~i_Full; all other ready bits are 0.
  - o_WR_En = i_Req_Valid[owner] & ~i_Full.
  - o_WR_Data = data slice of owner, and 0 when o_WR_En=0.
- Transfer: o_WR_En=1 at a posedge; count increments by 1.
- Release: release when a transfer has i_Req_Last[owner]=1, or when the transfer makes count==MAX_BURST. On release at that edge: state=IDLE, o_Grant=0, rr pointer=(owner+1) mod NUM_REQ, count=0.
- Release takes priority over simultaneous new requests. The next grant follows after 1 IDLE cycle, so there are at most MAX_BURST writes per NUM_REQ-fair round.
- Owner deasserts valid without last: grant is held (packet lock). No write occurs and count is unchanged.
- i_Full=1: ready and write enable are 0 and count is frozen. The grant is held indefinitely, with no timeout.
- Valid/last/data on non-owner requesters are ignored while in GRANT.
- Requesters must keep data stable while valid && !ready.
- Pointer wrap: owner NUM_REQ-1 sets pointer to 0.

Test Plan:
- Reset: assert i_WR_rst 2 cycles with all valids high -> o_WR_En=0, o_Grant=0, o_Req_Ready=0. First grant to req0 two edges after reset release.
- Round-robin: all 4 requesters valid, last on every word, i_Full=0 -> grant order 0,1,2,3,0. One write per grant, each write followed by one IDLE cycle.
- Burst cap: req2 alone sends 10 words, never last, MAX_BURST=4 -> writes in bursts of 4,4,2, with one idle gap between bursts. Remaining words wait, and o_Grant returns to req2 because no one else is requesting.
- Back-pressure: mid-burst on req1, i_Full=1 for 3 cycles -> o_WR_En=0 and o_Req_Ready=0 for those cycles; count holds. Resumes with the same data word when i_Full=0; no word is lost or duplicated (check the FIFO sequence 0x10..0x13).
- Packet lock: req0 owner sends 1 word, drops valid 2 cycles while req3 is valid -> o_Grant stays 0001, no write. req0 resumes and sends last -> next grant goes to req3 (pointer=1, scan 1,2,3).
- Reset mid-burst: assert i_WR_rst during the 2nd word of req1 -> o_Grant=0 the next cycle and the pointer returns to 0. Req0 is granted before req1 afterwards.
